// File: rtl/fphub_div_sequencer_if.sv
// Request, special-result, divider-core and response signals of the HUB divider front end.
// The sequencer uses the master view; the surrounding datapath uses the slave view.
interface fphub_div_sequencer_if #(
   parameter int M            = 23,
   parameter int E            = 8,
   parameter int SPECIAL_CASE = 7
);
   localparam int W  = E + M + 1;
   localparam int CW = $clog2(SPECIAL_CASE);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic [CW-1:0] spec_x_case;
   logic [CW-1:0] spec_y_case;
   logic [W-1:0]  spec_x;
   logic [W-1:0]  spec_y;
   logic [W-1:0]  spec_result;
   logic          core_start;
   logic [W-1:0]  core_x;
   logic [W-1:0]  core_y;
   logic          core_done;
   logic [W-1:0]  core_result;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_special;
   logic          out_timeout;

   modport master (
      input  in_valid, in_x, in_y, spec_result, core_done, core_result, out_ready,
      output in_ready, spec_x_case, spec_y_case, spec_x, spec_y,
             core_start, core_x, core_y, out_valid, out_result, out_special, out_timeout
   );

   modport slave (
      output in_valid, in_x, in_y, spec_result, core_done, core_result, out_ready,
      input  in_ready, spec_x_case, spec_y_case, spec_x, spec_y,
             core_start, core_x, core_y, out_valid, out_result, out_special, out_timeout
   );
endinterface

// File: rtl/fphub_div_sequencer.sv
// Front-end sequencer of the HUB divider: classifies an operand pair, then either takes the
// special-result unit's answer or runs the iterative core under a timeout, returning one result.
module fphub_div_sequencer #(
   parameter int M            = 23,
   parameter int E            = 8,
   parameter int SPECIAL_CASE = 7,
   parameter int TIMEOUT      = 64
) (
   input logic                   clk,
   input logic                   rst_n,
   fphub_div_sequencer_if.master bus
);
   localparam int W  = E + M + 1;
   localparam int CW = $clog2(SPECIAL_CASE);

   localparam logic [CW-1:0] C_NONE   = CW'(0);
   localparam logic [CW-1:0] C_INF_P  = CW'(1);
   localparam logic [CW-1:0] C_INF_N  = CW'(2);
   localparam logic [CW-1:0] C_ZERO_P = CW'(3);
   localparam logic [CW-1:0] C_ZERO_N = CW'(4);
   localparam logic [CW-1:0] C_ONE_P  = CW'(5);
   localparam logic [CW-1:0] C_ONE_N  = CW'(6);
   localparam logic [E-1:0]  EXP_ONE  = {1'b1, {(E-1){1'b0}}};
   localparam logic [7:0]    TIMEOUT_LOAD = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_DECIDE, S_SPECIAL, S_START, S_WAIT, S_RESP
   } state_t;

   state_t        state_reg, state_next;
   logic          run_reg;
   logic [W-1:0]  x_reg, y_reg, result_reg;
   logic [CW-1:0] x_case_reg, y_case_reg;
   logic [7:0]    cnt_reg;
   logic          special_reg, timeout_reg;

   logic [1:0][W-1:0]  operand;
   logic [1:0][CW-1:0] op_case;
   logic               bypass;
   logic               in_ready_c, core_start_c, out_valid_c;

   assign operand = {bus.in_y, bus.in_x};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_classify
         logic          sign;
         logic [E-1:0]  ex;
         logic [M-1:0]  man;
         logic [CW-1:0] cls;

         assign sign = operand[gi][W-1];
         assign ex   = operand[gi][W-2:M];
         assign man  = operand[gi][M-1:0];

         always_comb begin
            cls = C_NONE;
            if (&ex && &man)
               cls = sign ? C_INF_N : C_INF_P;
            else if (ex == '0 && man == '0)
               cls = sign ? C_ZERO_N : C_ZERO_P;
            else if (ex == EXP_ONE && man == '0)
               cls = sign ? C_ONE_N : C_ONE_P;
         end

         assign op_case[gi] = cls;
      end
   endgenerate

   // A unit dividend still needs the core unless the divisor is special too.
   assign bypass = (x_case_reg >= C_INF_P && x_case_reg <= C_ZERO_N) || (y_case_reg != C_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      in_ready_c   = 1'b0;
      core_start_c = 1'b0;
      out_valid_c  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            in_ready_c = run_reg;
            if (run_reg && bus.in_valid) state_next = S_DECIDE;
         end
         S_DECIDE:  state_next = bypass ? S_SPECIAL : S_START;
         S_SPECIAL: state_next = S_RESP;
         S_START: begin
            core_start_c = 1'b1;
            state_next   = S_WAIT;
         end
         S_WAIT:    if (bus.core_done || cnt_reg == 8'd1) state_next = S_RESP;
         S_RESP: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_next = S_IDLE;
         end
         default:   state_next = S_IDLE;
      endcase
   end

   // run_reg keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg     <= 1'b0;
         x_reg       <= '0;
         y_reg       <= '0;
         x_case_reg  <= '0;
         y_case_reg  <= '0;
         cnt_reg     <= '0;
         result_reg  <= '0;
         special_reg <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         case (state_reg)
            S_IDLE: begin
               if (in_ready_c && bus.in_valid) begin
                  x_reg      <= bus.in_x;
                  y_reg      <= bus.in_y;
                  x_case_reg <= op_case[0];
                  y_case_reg <= op_case[1];
               end
            end
            S_SPECIAL: begin
               result_reg  <= bus.spec_result;
               special_reg <= 1'b1;
               timeout_reg <= 1'b0;
            end
            S_START: cnt_reg <= TIMEOUT_LOAD;
            S_WAIT: begin
               cnt_reg <= cnt_reg - 8'd1;
               if (bus.core_done) begin
                  result_reg  <= bus.core_result;
                  special_reg <= 1'b0;
                  timeout_reg <= 1'b0;
               end else if (cnt_reg == 8'd1) begin
                  result_reg  <= '1;
                  special_reg <= 1'b0;
                  timeout_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.core_start  = core_start_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.spec_x_case = x_case_reg;
   assign bus.spec_y_case = y_case_reg;
   assign bus.spec_x      = x_reg;
   assign bus.spec_y      = y_reg;
   assign bus.core_x      = x_reg;
   assign bus.core_y      = y_reg;
   assign bus.out_result  = result_reg;
   assign bus.out_special = special_reg;
   assign bus.out_timeout = timeout_reg;
endmodule
